// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_THRESH = 2;
  localparam int DEF_AF_MARGIN = 2;  // almost_full default sits this far below DEPTH

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer side of the FIFO: requests, read data, flags and count.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int ADDR_W = clog2_f(DEPTH);

  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output we, wdata, re, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  we, wdata, re, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, threshold flags and sticky errors.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);

  localparam int ADDR_W = clog2_f(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0]   wptr_q, rptr_q, count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rd;

  // Accepts never look at the other side: no pass-through when full, no bypass when empty.
  always_comb begin
    wr_acc  = bus.we && !full_q;
    rd_acc  = bus.re && !empty_q;
    count_d = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.we && full_q)  ovf_d = 1'b1;
    if (bus.re && empty_q) udf_d = 1'b1;
  end

  // Pointers, count and flags; flags come from the next-state count so they are exact after the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (rd_acc) rptr_q <= rptr_q + 1'b1;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AF_C);
      aempty_q <= (count_d <= AE_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rd)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rdata = mem_rd;
    end else begin : g_std
      logic [DATA_W-1:0] rdata_q;
      // Registered read: capture the head word only on an accepted pop, otherwise hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem_rd;
      end
      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: one FWFT and one standard-mode FIFO (DEPTH=4) fed identical stimulus,
// checked each cycle against a queue model, plus hand-computed literal expectations.
module tb_fifo_sync_param;

  localparam int DW  = 8;
  localparam int DP  = 4;
  localparam int AFT = 3;
  localparam int AET = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [DW-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_f ();
  fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_s ();

  assign bus_f.we = we;  assign bus_f.wdata = wdata;  assign bus_f.re = re;  assign bus_f.clr_err = clr;
  assign bus_s.we = we;  assign bus_s.wdata = wdata;  assign bus_s.re = re;  assign bus_s.clr_err = clr;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1), .AF_THRESH(AFT), .AE_THRESH(AET))
    u_fwft (.clk(clk), .rst(rst), .bus(bus_f));
  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0), .AF_THRESH(AFT), .AE_THRESH(AET))
    u_std  (.clk(clk), .rst(rst), .bus(bus_s));

  // Reference model: contents as a queue, sticky error bits, last popped word.
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_std_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_std_rd = '0;
    end else begin
      bit can_wr, can_rd;
      can_wr = we && (mq.size() < DP);
      can_rd = re && (mq.size() > 0);
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (we && !can_wr) m_ovf = 1'b1;
      if (re && mq.size() == 0) m_udf = 1'b1;
      if (can_rd) m_std_rd = mq.pop_front();
      if (can_wr) mq.push_back(wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = mq.size();
      chk("f.count", 32'(bus_f.count), n);
      chk("f.empty", 32'(bus_f.empty), 32'(n == 0));
      chk("f.full",  32'(bus_f.full),  32'(n == DP));
      chk("f.af",    32'(bus_f.almost_full),  32'(n >= AFT));
      chk("f.ae",    32'(bus_f.almost_empty), 32'(n <= AET));
      chk("f.ovf",   32'(bus_f.overflow),  32'(m_ovf));
      chk("f.udf",   32'(bus_f.underflow), 32'(m_udf));
      if (n > 0) chk("f.rdata", 32'(bus_f.rdata), 32'(mq[0]));
      chk("s.count", 32'(bus_s.count), n);
      chk("s.empty", 32'(bus_s.empty), 32'(n == 0));
      chk("s.full",  32'(bus_s.full),  32'(n == DP));
      chk("s.ovf",   32'(bus_s.overflow),  32'(m_ovf));
      chk("s.udf",   32'(bus_s.underflow), 32'(m_udf));
      chk("s.rdata", 32'(bus_s.rdata), 32'(m_std_rd));
    end
  end

  // One clock of stimulus; returns 1ns after the edge with requests idle.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    @(negedge clk); #1;
    we = w; wdata = d; re = r; clr = c;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  logic [DW-1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;

    // Reset then idle.
    #12 rst = 1'b0;
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("rst.count", 32'(bus_f.count), 0);
    chk("rst.empty", 32'(bus_f.empty), 1);
    chk("rst.ae",    32'(bus_f.almost_empty), 1);
    chk("rst.full",  32'(bus_f.full), 0);
    chk("rst.af",    32'(bus_f.almost_full), 0);
    chk("rst.ovf",   32'(bus_f.overflow), 0);
    chk("rst.udf",   32'(bus_s.underflow), 0);
    chk("rst.srd",   32'(bus_s.rdata), 0);

    // Fill and drain in order.
    step(1, 8'h11, 0, 0);
    chk("fwft.first", 32'(bus_f.rdata), 32'h11);
    chk("fwft.nonempty", 32'(bus_f.empty), 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    chk("fill.full",  32'(bus_f.full), 1);
    chk("fill.count", 32'(bus_s.count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain.fwft", 32'(bus_f.rdata), 32'(exp_seq[i]));
      step(0, 8'h00, 1, 0);
      chk("drain.std", 32'(bus_s.rdata), 32'(exp_seq[i]));
      if (i == 0) chk("drain.fullfall", 32'(bus_f.full), 0);
    end
    chk("drain.empty", 32'(bus_f.empty), 1);

    // Full with simultaneous write+read: write rejected, pop happens.
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
    step(1, 8'h55, 1, 0);
    chk("ovf.count", 32'(bus_f.count), 3);
    chk("ovf.flag",  32'(bus_f.overflow), 1);
    chk("ovf.srd",   32'(bus_s.rdata), 32'h01);
    chk("ovf.fhead", 32'(bus_f.rdata), 32'h02);
    step(0, 8'h00, 0, 1);
    chk("ovf.clr",   32'(bus_f.overflow), 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    chk("ovf.lastpop", 32'(bus_s.rdata), 32'h04);

    // Empty with simultaneous write+read: write accepted, underflow set, std rdata held.
    step(1, 8'h66, 1, 0);
    chk("udf.count", 32'(bus_f.count), 1);
    chk("udf.flag",  32'(bus_s.underflow), 1);
    chk("udf.srdhold", 32'(bus_s.rdata), 32'h04);
    chk("udf.fhead", 32'(bus_f.rdata), 32'h66);
    step(0, 8'h00, 0, 1);
    chk("udf.clr",   32'(bus_s.underflow), 0);

    // Wrap-around: 10 back-to-back write+read pairs with one word resident.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h70 + i), 1, 0);
      chk("wrap.count", 32'(bus_f.count), 1);
      chk("wrap.srd",   32'(bus_s.rdata), (i == 0) ? 32'h66 : 32'(8'h70 + i - 1));
    end
    chk("wrap.fhead", 32'(bus_f.rdata), 32'h79);
    step(0, 8'h00, 1, 0);

    // Asynchronous reset mid-burst with three words resident.
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    chk("mid.count3", 32'(bus_f.count), 3);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst.count", 32'(bus_f.count), 0);
    chk("arst.empty", 32'(bus_f.empty), 1);
    chk("arst.ae",    32'(bus_s.almost_empty), 1);
    chk("arst.af",    32'(bus_f.almost_full), 0);
    chk("arst.srd",   32'(bus_s.rdata), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    step(0, 8'h00, 0, 0);
    chk("post.empty", 32'(bus_f.empty), 1);
    step(1, 8'hB5, 0, 0);
    chk("post.fhead", 32'(bus_f.rdata), 32'hB5);
    step(0, 8'h00, 1, 0);
    chk("post.srd",   32'(bus_s.rdata), 32'hB5);
    chk("post.empty2", 32'(bus_s.empty), 1);
    step(0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
